// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer: Avalon-MM master that puts the active effect name on the
// 16x2 character LCD. Each sequence is clear display, cursor home, then
// MSG_LEN characters on line 1; a change of mode restarts the sequence.
module lcd_msg_writer #(
  parameter int         MSG_LEN   = 16,
  parameter logic [7:0] CLEAR_CMD = 8'h01,
  parameter logic [7:0] HOME_CMD  = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
  output logic       address,
  output logic       chipselect,
  output logic       write,
  output logic [7:0] writedata,
  input  logic       waitrequest,
  output logic       busy,
  output logic       done
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  // Effect names, right-aligned in an 11-character field.
  localparam logic [87:0] STR_COLOUR = {40'h0, "COLOUR"};
  localparam logic [87:0] STR_BLUR   = {56'h0, "BLUR"};
  localparam logic [87:0] STR_BRIGHT = {8'h0, "BRIGHTNESS"};
  localparam logic [87:0] STR_EDGE   = "EDGE DETECT";

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HOME  = 3'd2,
    ST_CHARS = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Character pos of a right-aligned string of length len; space past its end.
  function automatic logic [7:0] str_char(input logic [87:0] str, input int len, input int pos);
    logic [87:0] shifted;
    logic [7:0]  ch;
    shifted = '0;
    if (pos < len) begin
      shifted = str >> (8 * (len - 1 - pos));
      ch      = shifted[7:0];
    end else begin
      ch = 8'h20;
    end
    return ch;
  endfunction

  // Message ROM: character i of the name for effect m, space padded.
  function automatic logic [7:0] rom_char(input logic [1:0] m, input logic [IDX_W-1:0] i);
    int         pos;
    logic [7:0] ch;
    pos = int'(i);
    case (m)
      2'd0:    ch = str_char(STR_COLOUR, 6, pos);
      2'd1:    ch = str_char(STR_BLUR, 4, pos);
      2'd2:    ch = str_char(STR_BRIGHT, 10, pos);
      2'd3:    ch = str_char(STR_EDGE, 11, pos);
      default: ch = 8'h20;
    endcase
    return ch;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             chipselect_q;
  logic             address_q, address_d;
  logic [7:0]       writedata_q, writedata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             restart_s;
  logic             load_clear_s;

  assign accept_s  = write_q & ~waitrequest;
  // A mode seen differing now or earlier (even if it has since returned) forces a restart.
  assign restart_s = pending_q | (mode != mode_q);

  // Next-state and next-output logic for the message sequencer.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pending_d    = restart_s;
    idx_d        = idx_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    load_clear_s = 1'b0;

    case (state_q)
      ST_START: begin
        load_clear_s = 1'b1;
      end
      ST_CLEAR: begin
        if (accept_s) begin
          if (restart_s) begin
            load_clear_s = 1'b1;
          end else begin
            state_d     = ST_HOME;
            address_d   = 1'b0;
            writedata_d = HOME_CMD;
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_HOME: begin
        if (accept_s) begin
          if (restart_s) begin
            load_clear_s = 1'b1;
          end else begin
            state_d     = ST_CHARS;
            idx_d       = {IDX_W{1'b0}};
            address_d   = 1'b1;
            writedata_d = rom_char(mode_q, {IDX_W{1'b0}});
          end
        end else begin
          state_d = ST_HOME;
        end
      end
      ST_CHARS: begin
        if (accept_s) begin
          if (restart_s) begin
            load_clear_s = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            write_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            writedata_d = rom_char(mode_q, idx_q + IDX_W'(1));
          end
        end else begin
          state_d = ST_CHARS;
        end
      end
      ST_DONE: begin
        if (restart_s) begin
          state_d = ST_START;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_START;
        write_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Starting (or restarting) a sequence: recapture mode and present the clear command.
    if (load_clear_s) begin
      state_d     = ST_CLEAR;
      mode_d      = mode;
      pending_d   = 1'b0;
      idx_d       = {IDX_W{1'b0}};
      write_d     = 1'b1;
      address_d   = 1'b0;
      writedata_d = CLEAR_CMD;
      busy_d      = 1'b1;
      done_d      = 1'b0;
    end else begin
      pending_d = restart_s;
    end
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_START;
      mode_q       <= 2'd0;
      pending_q    <= 1'b0;
      idx_q        <= {IDX_W{1'b0}};
      write_q      <= 1'b0;
      chipselect_q <= 1'b0;
      address_q    <= 1'b0;
      writedata_q  <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      write_q      <= write_d;
      chipselect_q <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign address    = address_q;
  assign chipselect = chipselect_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Self-checking bench for lcd_msg_writer: accepted beats are collected and
// compared with the beat list built from the effect names.
module tb_lcd_msg_writer;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       waitrequest;
  logic       address;
  logic       chipselect;
  logic       write;
  logic [7:0] writedata;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  string      names [4];
  logic [8:0] obs_q [$];

  logic       p_write;
  logic       p_addr;
  logic [7:0] p_data;
  logic       p_wait;

  lcd_msg_writer dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .mode        (mode),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of the message for effect m: {address, byte}.
  function automatic logic [8:0] exp_beat(input int m, input int k);
    string s;
    s = names[m];
    if (k == 0) return {1'b0, 8'h01};
    if (k == 1) return {1'b0, 8'h80};
    if (k - 2 < s.len()) return {1'b1, s[k-2]};
    return {1'b1, 8'h20};
  endfunction

  // Advance one clock: log an accepted beat, snapshot pre-edge values, step past the edge.
  task automatic tick();
    if (write === 1'b1 && waitrequest === 1'b0) obs_q.push_back({address, writedata});
    p_write = write;
    p_addr  = address;
    p_data  = writedata;
    p_wait  = waitrequest;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    logic [8:0] got;
    rst_n = 1'b0; waitrequest = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %0b want 0", write); end
    checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %0b want 0", chipselect); end
    checks++; if (address !== 1'b0) begin errors++; $display("FAIL reset_addr got %0b want 0", address); end
    checks++; if (writedata !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 00", writedata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b%0b want 00", busy, done); end
    rst_n = 1'b1;
    obs_q.delete();
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if ({write, busy, address, writedata} !== {1'b1, 1'b1, 1'b0, 8'h01}) begin
          errors++; $display("FAIL first_beat got w%0b b%0b a%0b d%0h want w1 b1 a0 d01", write, busy, address, writedata);
        end
      end
    end
    checks++; if (n != 19) begin errors++; $display("FAIL done_latency got %0d want 19", n); end
    checks++; if (busy !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL done_idle got busy %0b write %0b want 0 0", busy, write); end
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL t1_count got %0d want 18", obs_q.size()); end
    for (int k = 0; k < 18; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      checks++; if (got !== exp_beat(0, k)) begin errors++; $display("FAIL t1_beat%0d got %0h want %0h", k, got, exp_beat(0, k)); end
    end
  endtask

  task automatic test_stall();
    int hcnt;
    int wcyc;
    int n;
    logic [8:0] got;
    mode = 2'd2; waitrequest = 1'b0;
    obs_q.delete();
    tick();
    hcnt = 0; wcyc = 0; n = 0;
    while (done !== 1'b1 && n < 300) begin
      waitrequest = (write === 1'b1 && hcnt < 3);
      tick();
      n++;
      if (p_write === 1'b1) wcyc++;
      if (p_write === 1'b1 && p_wait === 1'b1) begin
        hcnt++;
        checks++;
        if ({write, address, writedata} !== {1'b1, p_addr, p_data}) begin
          errors++; $display("FAIL stall_hold got w%0b a%0b d%0h want w1 a%0b d%0h", write, address, writedata, p_addr, p_data);
        end
        checks++;
        if (chipselect !== write) begin errors++; $display("FAIL cs_eq_write got %0b want %0b", chipselect, write); end
      end else begin
        hcnt = 0;
      end
    end
    checks++; if (wcyc != 72) begin errors++; $display("FAIL stall_cycles got %0d want 72", wcyc); end
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL t2_count got %0d want 18", obs_q.size()); end
    for (int k = 0; k < 18; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      checks++; if (got !== exp_beat(2, k)) begin errors++; $display("FAIL t2_beat%0d got %0h want %0h", k, got, exp_beat(2, k)); end
    end
  endtask

  task automatic test_mode_change_done();
    int n;
    logic [8:0] got;
    mode = 2'd3; waitrequest = 1'b0;
    obs_q.delete();
    tick();
    if (write !== 1'b1) tick();
    checks++;
    if ({write, address, writedata} !== {1'b1, 1'b0, 8'h01}) begin
      errors++; $display("FAIL restart_beat got w%0b a%0b d%0h want w1 a0 d01", write, address, writedata);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_timeout got done %0b want 1", done); end
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL t3_count got %0d want 18", obs_q.size()); end
    for (int k = 0; k < 18; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      checks++; if (got !== exp_beat(3, k)) begin errors++; $display("FAIL t3_beat%0d got %0h want %0h", k, got, exp_beat(3, k)); end
    end
  endtask

  task automatic test_mode_change_mid();
    int n;
    logic [8:0] got;
    logic [8:0] want;
    mode = 2'd0; waitrequest = 1'b0;
    obs_q.delete();
    n = 0;
    while (!(write === 1'b1 && address === 1'b1 && writedata === 8'h55) && n < 40) begin tick(); n++; end
    checks++; if (writedata !== 8'h55) begin errors++; $display("FAIL t4_reach_u got %0h want 55", writedata); end
    waitrequest = 1'b1; mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({write, address, writedata} !== {1'b1, 1'b1, 8'h55}) begin
        errors++; $display("FAIL t4_hold_u got w%0b a%0b d%0h want w1 a1 d55", write, address, writedata);
      end
    end
    waitrequest = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (obs_q.size() != 25) begin errors++; $display("FAIL t4_count got %0d want 25", obs_q.size()); end
    for (int k = 0; k < 25; k++) begin
      got  = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      want = (k < 7) ? exp_beat(0, k) : exp_beat(1, k - 7);
      checks++; if (got !== want) begin errors++; $display("FAIL t4_beat%0d got %0h want %0h", k, got, want); end
    end
  endtask

  task automatic test_mode_glitch();
    int n;
    logic [8:0] got;
    logic [8:0] want;
    rst_n = 1'b0; waitrequest = 1'b0; mode = 2'd1;
    tick(); tick();
    rst_n = 1'b1;
    obs_q.delete();
    n = 0;
    while (obs_q.size() < 3 && n < 40) begin tick(); n++; end
    waitrequest = 1'b1; mode = 2'd2;
    tick();
    mode = 2'd1;
    tick(); tick();
    checks++;
    if ({write, address, writedata} !== {1'b1, 1'b1, 8'h4C}) begin
      errors++; $display("FAIL t5_hold got w%0b a%0b d%0h want w1 a1 d4c", write, address, writedata);
    end
    waitrequest = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (obs_q.size() != 22) begin errors++; $display("FAIL t5_count got %0d want 22", obs_q.size()); end
    for (int k = 0; k < 22; k++) begin
      got  = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      want = (k < 4) ? exp_beat(1, k) : exp_beat(1, k - 4);
      checks++; if (got !== want) begin errors++; $display("FAIL t5_beat%0d got %0h want %0h", k, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [8:0] got;
    mode = 2'd3; waitrequest = 1'b0;
    obs_q.delete();
    n = 0;
    while (obs_q.size() < 5 && n < 40) begin tick(); n++; end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({write, chipselect, address, writedata, busy, done} !== 13'h0) begin
      errors++; $display("FAIL async_reset got w%0b cs%0b a%0b d%0h b%0b dn%0b want all 0", write, chipselect, address, writedata, busy, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL t6_count got %0d want 18", obs_q.size()); end
    for (int k = 0; k < 18; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
      checks++; if (got !== exp_beat(3, k)) begin errors++; $display("FAIL t6_beat%0d got %0h want %0h", k, got, exp_beat(3, k)); end
    end
  endtask

  task automatic test_random();
    int cur;
    int m;
    int n;
    logic [8:0] got;
    cur = 3;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, 3);
      mode = 2'(m);
      obs_q.delete();
      if (m == cur) begin
        for (int i = 0; i < 3; i++) begin
          waitrequest = 1'($urandom_range(0, 1));
          tick();
        end
        checks++;
        if (write !== 1'b0 || done !== 1'b1 || obs_q.size() != 0) begin
          errors++; $display("FAIL rand_idle got w%0b done%0b beats %0d want 0 1 0", write, done, obs_q.size());
        end
      end else begin
        waitrequest = 1'b0;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 400) begin
          waitrequest = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL rand_count got %0d want 18", obs_q.size()); end
        for (int k = 0; k < 18; k++) begin
          got = (k < obs_q.size()) ? obs_q[k] : 9'h1FF;
          checks++; if (got !== exp_beat(m, k)) begin errors++; $display("FAIL rand_beat%0d got %0h want %0h", k, got, exp_beat(m, k)); end
        end
      end
      cur = m;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    names[0] = "COLOUR";
    names[1] = "BLUR";
    names[2] = "BRIGHTNESS";
    names[3] = "EDGE DETECT";
    rst_n = 1'b0;
    mode = 2'd0;
    waitrequest = 1'b0;
    test_reset();
    test_stall();
    test_mode_change_done();
    test_mode_change_mid();
    test_mode_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
